// File: rtl/cdb_arbiter_if.sv
// Handshake bundle between the reservation-station wrappers and the CDB arbiter.
// The arbiter takes the master side and drives the grant and the grant counter.
interface cdb_arbiter_if #(
   parameter int NUM_SOURCES = 8
);
   logic [NUM_SOURCES-1:0] complete;
   logic                   hold;
   logic                   flush;
   logic [31:0]            selection;
   logic                   sel_load;
   logic [15:0]            grant_count;

   modport master (
      input  complete, hold, flush,
      output selection, sel_load, grant_count
   );

   modport slave (
      output complete, hold, flush,
      input  selection, sel_load, grant_count
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter. It grants one completing station per cycle
// from a flopped grant register, and masks the station already on the bus so it is not granted twice.
module cdb_arbiter #(
   parameter int NUM_SOURCES = 8,
   parameter int FIRST_ID    = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   cdb_arbiter_if.master bus
);
   localparam int PW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   logic [PW-1:0]          ptr_reg;
   logic                   sel_load_reg;
   logic [31:0]            selection_reg;
   logic [15:0]            grant_count_reg;

   logic [31:0]            inflight_idx;
   logic [NUM_SOURCES-1:0] inflight;
   logic [NUM_SOURCES-1:0] eligible;

   logic                   found_hi;
   logic                   found_lo;
   logic [PW-1:0]          pick_hi;
   logic [PW-1:0]          pick_lo;
   logic                   found_next;
   logic [PW-1:0]          pick_next;
   logic [PW-1:0]          ptr_next;

   // The granted station keeps complete high until the next edge, so hide it.
   assign inflight_idx = selection_reg - 32'(FIRST_ID);

   generate
      for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_mask
         assign inflight[gi] = sel_load_reg && (inflight_idx == 32'(gi));
         assign eligible[gi] = bus.complete[gi] && !inflight[gi];
      end
   endgenerate

   // Rotating priority: lowest eligible index at or above ptr, else lowest below ptr.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (eligible[i]) begin
            if (i >= int'(ptr_reg)) begin
               if (!found_hi) begin
                  found_hi = 1'b1;
                  pick_hi  = PW'(i);
               end
            end else begin
               if (!found_lo) begin
                  found_lo = 1'b1;
                  pick_lo  = PW'(i);
               end
            end
         end
      end
      found_next = found_hi || found_lo;
      pick_next  = found_hi ? pick_hi : pick_lo;
      ptr_next   = (pick_next == PW'(NUM_SOURCES - 1)) ? '0 : pick_next + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg         <= '0;
         sel_load_reg    <= 1'b0;
         selection_reg   <= '0;
         grant_count_reg <= '0;
      end else if (bus.flush || bus.hold) begin
         sel_load_reg  <= 1'b0;
         selection_reg <= '0;
      end else if (found_next) begin
         sel_load_reg    <= 1'b1;
         selection_reg   <= 32'(FIRST_ID) + 32'(pick_next);
         ptr_reg         <= ptr_next;
         grant_count_reg <= grant_count_reg + 16'd1;
      end else begin
         sel_load_reg  <= 1'b0;
         selection_reg <= '0;
      end
   end

   assign bus.sel_load    = sel_load_reg;
   assign bus.selection   = selection_reg;
   assign bus.grant_count = grant_count_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, async-reset sequence, then random
// stimulus compared against a rotating-priority reference model.
module tb_cdb_arbiter;
   localparam int N     = 8;
   localparam int FIRST = 1;
   localparam int NVEC  = 26;

   logic clk;
   logic reset_n;

   cdb_arbiter_if #(.NUM_SOURCES(N)) bus ();

   cdb_arbiter #(.NUM_SOURCES(N), .FIRST_ID(FIRST)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  complete;
      logic        hold;
      logic        flush;
      logic        exp_load;
      logic [31:0] exp_sel;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [NVEC];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: pointer, last grant, counter
   int          m_ptr;
   bit          m_load;
   int          m_sel;
   logic [15:0] m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic exp_load,
                                input logic [31:0] exp_sel, input logic [15:0] exp_cnt);
      check({tag, ".sel_load"},    {31'd0, bus.sel_load}, {31'd0, exp_load});
      check({tag, ".selection"},   bus.selection,         exp_sel);
      check({tag, ".grant_count"}, {16'd0, bus.grant_count}, {16'd0, exp_cnt});
   endtask

   task automatic drive(input logic [7:0] c, input logic h, input logic f);
      bus.complete = c;
      bus.hold     = h;
      bus.flush    = f;
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_load = 0;
      m_sel  = 0;
      m_cnt  = '0;
   endtask

   // Next-edge behaviour computed straight from the arbitration rules
   task automatic model_step(input logic [7:0] c, input logic h, input logic f);
      logic [7:0] elig;
      int         k;
      bit         found;
      if (f || h) begin
         m_load = 0;
         m_sel  = 0;
      end else begin
         elig = c;
         if (m_load) elig = elig & ~(8'd1 << (m_sel - FIRST));
         found = 0;
         k     = 0;
         for (int o = 0; o < N; o++) begin
            int idx;
            idx = (m_ptr + o) % N;
            if (!found && ((elig >> idx) & 8'd1) != 0) begin
               found = 1;
               k     = idx;
            end
         end
         if (found) begin
            m_load = 1;
            m_sel  = FIRST + k;
            m_ptr  = (k + 1) % N;
            m_cnt  = m_cnt + 16'd1;
         end else begin
            m_load = 0;
            m_sel  = 0;
         end
      end
   endtask

   initial begin
      // rotation over all sources, each dropping after its grant
      vecs[0]  = '{8'hFF, 1'b0, 1'b0, 1'b1, 32'd1, 16'd1};
      vecs[1]  = '{8'hFE, 1'b0, 1'b0, 1'b1, 32'd2, 16'd2};
      vecs[2]  = '{8'hFC, 1'b0, 1'b0, 1'b1, 32'd3, 16'd3};
      vecs[3]  = '{8'hF8, 1'b0, 1'b0, 1'b1, 32'd4, 16'd4};
      vecs[4]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 32'd5, 16'd5};
      vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 32'd6, 16'd6};
      vecs[6]  = '{8'hC0, 1'b0, 1'b0, 1'b1, 32'd7, 16'd7};
      vecs[7]  = '{8'h80, 1'b0, 1'b0, 1'b1, 32'd8, 16'd8};
      vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 16'd8};
      // single station 3, held one extra cycle: inflight mask blocks a repeat
      vecs[9]  = '{8'h04, 1'b0, 1'b0, 1'b1, 32'd3, 16'd9};
      vecs[10] = '{8'h04, 1'b0, 1'b0, 1'b0, 32'd0, 16'd9};
      vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 16'd9};
      // station 2 (bit 1) held an extra cycle
      vecs[12] = '{8'h02, 1'b0, 1'b0, 1'b1, 32'd2, 16'd10};
      vecs[13] = '{8'h02, 1'b0, 1'b0, 1'b0, 32'd0, 16'd10};
      vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 16'd10};
      // ptr driven to N-1, then only bit 0 eligible
      vecs[15] = '{8'h40, 1'b0, 1'b0, 1'b1, 32'd7, 16'd11};
      vecs[16] = '{8'h01, 1'b0, 1'b0, 1'b1, 32'd1, 16'd12};
      vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 16'd12};
      // hold for three cycles, then resume from ptr=1
      vecs[18] = '{8'hFF, 1'b1, 1'b0, 1'b0, 32'd0, 16'd12};
      vecs[19] = '{8'hFF, 1'b1, 1'b0, 1'b0, 32'd0, 16'd12};
      vecs[20] = '{8'hFF, 1'b1, 1'b0, 1'b0, 32'd0, 16'd12};
      vecs[21] = '{8'hFF, 1'b0, 1'b0, 1'b1, 32'd2, 16'd13};
      vecs[22] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 16'd13};
      // flush with a pick available, then the same pick goes through
      vecs[23] = '{8'h10, 1'b0, 1'b1, 1'b0, 32'd0, 16'd13};
      vecs[24] = '{8'h10, 1'b0, 1'b0, 1'b1, 32'd5, 16'd14};
      vecs[25] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 16'd14};

      reset_n = 1'b0;
      drive(8'h00, 1'b0, 1'b0);
      #12;
      check_outputs("reset", 1'b0, 32'd0, 16'd0);
      reset_n = 1'b1;

      for (int v = 0; v < NVEC; v++) begin
         drive(vecs[v].complete, vecs[v].hold, vecs[v].flush);
         @(posedge clk);
         #1;
         $display("vec %0d complete=%02h hold=%0b flush=%0b -> sel_load=%0b selection=%0d count=%0d",
                  v, vecs[v].complete, vecs[v].hold, vecs[v].flush,
                  bus.sel_load, bus.selection, bus.grant_count);
         check_outputs($sformatf("vec%0d", v), vecs[v].exp_load, vecs[v].exp_sel, vecs[v].exp_cnt);
      end

      // Asynchronous reset while a grant is on the bus (ptr is 5 here)
      drive(8'h08, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("pre_reset_grant", 1'b1, 32'd4, 16'd15);
      #2;
      reset_n = 1'b0;
      #1;
      $display("async reset mid-grant -> sel_load=%0b selection=%0d count=%0d",
               bus.sel_load, bus.selection, bus.grant_count);
      check_outputs("async_reset", 1'b0, 32'd0, 16'd0);
      drive(8'h30, 1'b0, 1'b0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      $display("post reset complete=30 -> sel_load=%0b selection=%0d", bus.sel_load, bus.selection);
      check_outputs("post_reset_first", 1'b1, 32'd5, 16'd1);
      drive(8'h20, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("post_reset_second", 1'b1, 32'd6, 16'd2);

      // Random stimulus against the reference model
      drive(8'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int t = 0; t < 400; t++) begin
         logic [7:0] c;
         logic       h;
         logic       f;
         c = 8'($urandom);
         h = ($urandom_range(0, 7) == 0);
         f = ($urandom_range(0, 9) == 0);
         drive(c, h, f);
         model_step(c, h, f);
         @(posedge clk);
         #1;
         $display("rnd %0d complete=%02h hold=%0b flush=%0b -> sel_load=%0b selection=%0d (model %0b/%0d)",
                  t, c, h, f, bus.sel_load, bus.selection, m_load, m_sel);
         check_outputs($sformatf("rnd%0d", t), m_load, 32'(m_sel), m_cnt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
